dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_store_buffer.sv | 100 ++++++++++
 rtl/dmem_responder.sv | 60 ++++++
 tb/tb_dmem_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Word index width follows the default array depth.
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_SB_DEPTH    = 4;
  localparam int AW                  = $clog2(DEFAULT_DEPTH_WORDS);

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } sb_entry_t;

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    return addr[AW+1:2];
  endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// Store-buffer FIFO with age-ordered lookup for the data-memory responder.
// Optional in-place coalescing of same-index stores under DMEM_COALESCE_EN.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter  int SB_DEPTH = DEFAULT_SB_DEPTH,
  localparam int PW       = $clog2(SB_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          store_i,
  input  logic          idle_i,
  input  logic [AW-1:0] st_idx_i,
  input  logic [31:0]   st_data_i,
  input  logic [AW-1:0] lk_idx_i,
  output logic          hit_o,
  output logic [31:0]   hit_data_o,
  output sb_entry_t     head_o,
  output logic          drain_o,
  output logic          enq_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  sb_entry_t     buf_q [SB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] slot;
  logic          coalesce;
`ifdef DMEM_COALESCE_EN
  logic          st_hit;
  logic [PW-1:0] st_slot;
`endif

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(SB_DEPTH));
  assign head_o  = buf_q[head_q];

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    slot       = '0;
`ifdef DMEM_COALESCE_EN
    st_hit     = 1'b0;
    st_slot    = '0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      slot = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (buf_q[slot].idx == lk_idx_i) begin
          hit_o      = 1'b1;
          hit_data_o = buf_q[slot].data;
        end
`ifdef DMEM_COALESCE_EN
        if (buf_q[slot].idx == st_idx_i) begin
          st_hit  = 1'b1;
          st_slot = slot;
        end
`endif
      end
    end
  end

  always_comb begin
    coalesce = 1'b0;
`ifdef DMEM_COALESCE_EN
    // A match on the head being force-drained cannot be patched in place.
    coalesce = store_i && st_hit && !(full_o && (st_slot == head_q));
`endif
    enq_o   = store_i && !coalesce;
    drain_o = (idle_i && !empty_o) || (enq_o && full_o);
    count_d = count_q;
    if (enq_o && !drain_o)      count_d = count_q + 1'b1;
    else if (drain_o && !enq_o) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_o)   tail_q <= tail_q + 1'b1;
      if (drain_o) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_o) buf_q[tail_q] <= '{idx: st_idx_i, data: st_data_i};
`ifdef DMEM_COALESCE_EN
    if (coalesce) buf_q[st_slot].data <= st_data_i;
`endif
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: word array plus buffered stores, combinational loads.
// Build with DMEM_COALESCE_EN to merge same-index stores in the buffer.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter  int SB_DEPTH    = DEFAULT_SB_DEPTH,
  localparam int CW          = $clog2(SB_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [31:0]   ALUOutM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic [CW-1:0] sb_count,
  output logic          sb_empty,
  output logic          sb_full
);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          is_store, is_idle;
  logic          hit, drain, sb_enq_unused;
  logic [31:0]   hit_data;
  sb_entry_t     head;
  logic          unused_addr;

  assign idx         = word_index(ALUOutM);
  assign unused_addr = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};
  assign is_store    = MemWriteM;
  assign is_idle     = !MemWriteM && !MemReadM;

  dmem_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk_i      (clk),
    .rst_i      (reset),
    .store_i    (is_store),
    .idle_i     (is_idle),
    .st_idx_i   (idx),
    .st_data_i  (WriteDataM),
    .lk_idx_i   (idx),
    .hit_o      (hit),
    .hit_data_o (hit_data),
    .head_o     (head),
    .drain_o    (drain),
    .enq_o      (sb_enq_unused),
    .count_o    (sb_count),
    .empty_o    (sb_empty),
    .full_o     (sb_full)
  );

  // Array is deliberately left unreset; only the buffer state is cleared.
  always_ff @(posedge clk) begin
    if (drain) mem_q[head.idx] <= head.data;
  end

  assign ReadDataM = hit ? hit_data : mem_q[idx];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  logic        clk, reset, MemWriteM, MemReadM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic [2:0]  sb_count;
  logic        sb_empty, sb_full;
  int          errors = 0;
  int          checks = 0;

`ifdef DMEM_COALESCE_EN
  localparam logic [31:0] DUP_COUNT = 32'd1;
`else
  localparam logic [31:0] DUP_COUNT = 32'd2;
`endif

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty),
    .sb_full    (sb_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWriteM = 1'b1; MemReadM = 1'b0; ALUOutM = a; WriteDataM = d;
    cyc();
  endtask

  task automatic idle(input int n);
    MemWriteM = 1'b0; MemReadM = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWriteM = 1'b0; MemReadM = 1'b1; ALUOutM = a; WriteDataM = '0;
    #1;
    chk(tag, ReadDataM, exp);
  endtask

  initial begin
    reset = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; ALUOutM = '0; WriteDataM = '0;
    #1;
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_full",  32'(sb_full),  32'd0);
    cyc(); cyc();
    reset = 1'b0;
    idle(1);
    chk("idle_empty", 32'(sb_empty), 32'd1);

    // preload array[5] through the buffer
    store(32'h14, 32'h11);
    idle(1);
    chk("preload_drained", 32'(sb_count), 32'd0);
    load_chk("load_preload", 32'h14, 32'h11);

    // forwarding, then drain with unchanged result
    store(32'h14, 32'hAAAA0001);
    load_chk("fwd_data", 32'h14, 32'hAAAA0001);
    chk("fwd_count", 32'(sb_count), 32'd1);
    cyc();
    chk("load_no_drain", 32'(sb_count), 32'd1);
    idle(1);
    chk("drain_count", 32'(sb_count), 32'd0);
    load_chk("post_drain", 32'h14, 32'hAAAA0001);
    cyc();

    // fill, then forced drain on fifth store
    store(32'h0, 32'h100);
    store(32'h4, 32'h101);
    store(32'h8, 32'h102);
    store(32'hC, 32'h103);
    chk("fill_full",  32'(sb_full),  32'd1);
    chk("fill_count", 32'(sb_count), 32'd4);
    store(32'h10, 32'h5);
    chk("forced_count", 32'(sb_count), 32'd4);
    chk("forced_full",  32'(sb_full),  32'd1);
    chk("array0_direct", dut.mem_q[0], 32'h100);
    load_chk("ld_0",  32'h0,  32'h100);
    load_chk("ld_4",  32'h4,  32'h101);
    load_chk("ld_8",  32'h8,  32'h102);
    load_chk("ld_C",  32'hC,  32'h103);
    load_chk("ld_10", 32'h10, 32'h5);
    idle(4);
    chk("fill_drained", 32'(sb_empty), 32'd1);
    load_chk("ld_10_arr", 32'h10, 32'h5);
    load_chk("ld_C_arr",  32'hC,  32'h103);

    // back-to-back stores to the same index
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    load_chk("dup_youngest", 32'h20, 32'h2);
    chk("dup_count", 32'(sb_count), DUP_COUNT);
    idle(2);
    chk("dup_drained", 32'(sb_empty), 32'd1);
    load_chk("dup_arr", 32'h20, 32'h2);

    // asynchronous reset mid-cycle discards buffered stores
    store(32'h0, 32'hDEAD0000);
    store(32'h4, 32'hDEAD0001);
    store(32'h8, 32'hDEAD0002);
    chk("pre_rst_count", 32'(sb_count), 32'd3);
    MemWriteM = 1'b0; MemReadM = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(sb_count), 32'd0);
    chk("async_rst_empty", 32'(sb_empty), 32'd1);
    cyc();
    reset = 1'b0;
    idle(1);
    load_chk("lost_0", 32'h0, 32'h100);
    load_chk("lost_4", 32'h4, 32'h101);
    load_chk("lost_8", 32'h8, 32'h102);
    cyc();

    // address aliasing on index bits only
    store(32'h400, 32'h77);
    load_chk("alias_hi", 32'h0, 32'h77);
    cyc();
    store(32'h3, 32'h9);
    load_chk("alias_lo", 32'h0, 32'h9);
    idle(2);
    chk("alias_drained", 32'(sb_empty), 32'd1);
    load_chk("alias_arr", 32'h0, 32'h9);
    load_chk("alias_arr_hi", 32'h400, 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
